alu_sequencer: RTL and testbench
================================

Name: alu_sequencer

Overview:
- Multi-cycle controller wrapped around the team's 4-bit integer ALU function set: logic gates, add/sub, shift, multiply, divide.
- Accepts one command per transaction on a valid/ready handshake and captures the operands.
- Logic, add/sub and shift complete in a single execute cycle. Multiply runs iterative shift-add and divide runs restoring division, each over WIDTH execute cycles.
- Holds the result on a valid/ready output handshake. Sits between the top-level command source and the register file or writeback.

Parameters:
- WIDTH, 4, operand width; result is 2*WIDTH bits.

Ports:
- clock  in  1  system clock; all state updates on the rising edge
- reset  in  1  synchronous, active-low reset
- cmd_valid  in  1  command present
- cmd_ready  out  1  sequencer can accept a command; high only in IDLE
- opcode  in  4  operation select (encoding below)
- a  in  WIDTH  operand A
- b  in  WIDTH  operand B
- carry_in  in  1  carry input, used by ADD only
- res_valid  out  1  result, flags valid; high only in DONE
- res_ready  in  1  consumer accepts result
- result  out  2*WIDTH  operation result
- carry_out  out  1  carry / no-borrow / shifted-out bit
- div_zero  out  1  DIV attempted with b==0
- illegal_op  out  1  opcode not in the encoding
- busy  out  1  state != IDLE

Behaviour:
- Reset (reset==0 at an edge):
  - State goes to IDLE.
  - result, carry_out, div_zero, illegal_op, res_valid and busy all go to 0; cmd_ready goes to 1.
  - Internal operand, accumulator and counter registers are cleared.
  - Reset overrides every other input, including mid-EXEC and in DONE with res_ready low; an in-flight result is discarded.
- Opcode encoding:
  - 0 AND, 1 NAND, 2 OR, 3 NOR, 4 XOR, 5 XNOR.
  - 6 NOT: ~a only.
  - 7 ADD, 8 SUB, 9 MUL, 10 DIV, 11 SHL, 12 SHR.
  - 13-15 are illegal.
- FSM states: IDLE, EXEC, DONE.
  - IDLE: when cmd_valid && cmd_ready at an edge, latch opcode, a, b and carry_in, load counter = WIDTH-1, and go to EXEC. Otherwise remain in IDLE.
  - EXEC, single-cycle ops (0-8, 11, 12, illegal, and DIV with b==0): result and flags are registered on the next edge and the state goes to DONE. res_valid is high 2 cycles after the accept edge.
  - EXEC, MUL and DIV (b!=0): one iteration per cycle for WIDTH cycles. After the final iteration (counter==0) the state goes to DONE. res_valid is high WIDTH+1 cycles after the accept edge, i.e. 5 cycles at WIDTH=4.
  - DONE: result and flags are held stable. On res_valid && res_ready go to IDLE; cmd_ready rises the following cycle. There is no command overlap or back-to-back accept.
- cmd_valid is ignored outside IDLE. Inputs a, b and opcode may change freely after the accept edge without affecting the operation.
- Arithmetic and width rules (WIDTH=4):
  - Logic ops, NOT: result[3:0] = op(a,b); result[7:4] = 0; carry_out = 0.
  - ADD: {carry_out, result[3:0]} = a + b + carry_in.
  - SUB: result[3:0] = (a - b) mod 16; carry_out = 1 iff a >= b (no borrow); carry_in is ignored.
  - SHL: result[3:0] = {a[2:0], 0}; carry_out = a[3].
  - SHR: result[3:0] = {0, a[3:1]}; carry_out = a[0]. Shifts are logical and ignore b.
  - MUL: result = a*b, unsigned 8-bit product, computed by shift-add, LSB of b first; carry_out = 0.
  - DIV (b!=0): unsigned restoring division, MSB first. result[3:0] = quotient, result[7:4] = remainder; carry_out = 0.
  - DIV (b==0): div_zero = 1, result[3:0] = 4'hF, result[7:4] = a; completes in the single-cycle path.
  - Illegal opcode: illegal_op = 1, result = 0, carry_out = 0.
- Flags div_zero and illegal_op are valid only with res_valid and are cleared on the accept edge of the next command.
- Counter wrap-around: the counter decrements only in EXEC for MUL/DIV and never underflows; the transition to DONE occurs at counter==0.

Test Plan:
- Reset: hold reset=0 for 2 cycles mid-MUL (a=15, b=15) -> next cycle state IDLE, cmd_ready=1, res_valid=0, result=0; no stale result appears later.
- ADD: a=4'hF, b=4'h1, carry_in=1 -> res_valid 2 cycles after accept, result=8'h01, carry_out=1. SUB a=3, b=5 -> result=8'h0E, carry_out=0.
- MUL latency: a=15, b=15 -> res_valid exactly 5 cycles after accept, result=8'hE1. a=0, b=9 -> result=8'h00.
- DIV: a=13, b=4 -> result=8'h13 (remainder 1, quotient 3), div_zero=0, latency 5. a=7, b=0 -> result=8'h7F, div_zero=1, latency 2.
- Back-pressure: complete XOR a=4'hC, b=4'h3 with res_ready=0 for 6 cycles, cmd_valid held high with new operands -> result=8'h0F held stable, cmd_ready=0, second command accepted only the cycle after res_ready=1.
- Illegal/shift: opcode=14 -> illegal_op=1, result=0. SHL a=4'b1001 -> result=8'h02, carry_out=1. SHR a=4'b1001 -> result=8'h04, carry_out=1.

Source files
------------

// File: rtl/alu_sequencer.sv
// Multi-cycle sequencer around the 4-bit ALU function set.
// Single-cycle logic/add/sub/shift; iterative shift-add MUL and restoring DIV.
module alu_sequencer #(
  parameter int WIDTH = 4
) (
  input  logic               clock,
  input  logic               reset,
  input  logic               cmd_valid,
  output logic               cmd_ready,
  input  logic [3:0]         opcode,
  input  logic [WIDTH-1:0]   a,
  input  logic [WIDTH-1:0]   b,
  input  logic               carry_in,
  output logic               res_valid,
  input  logic               res_ready,
  output logic [2*WIDTH-1:0] result,
  output logic               carry_out,
  output logic               div_zero,
  output logic               illegal_op,
  output logic               busy
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  localparam logic [3:0] OP_AND  = 4'd0;
  localparam logic [3:0] OP_NAND = 4'd1;
  localparam logic [3:0] OP_OR   = 4'd2;
  localparam logic [3:0] OP_NOR  = 4'd3;
  localparam logic [3:0] OP_XOR  = 4'd4;
  localparam logic [3:0] OP_XNOR = 4'd5;
  localparam logic [3:0] OP_NOT  = 4'd6;
  localparam logic [3:0] OP_ADD  = 4'd7;
  localparam logic [3:0] OP_SUB  = 4'd8;
  localparam logic [3:0] OP_MUL  = 4'd9;
  localparam logic [3:0] OP_DIV  = 4'd10;
  localparam logic [3:0] OP_SHL  = 4'd11;
  localparam logic [3:0] OP_SHR  = 4'd12;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_EXEC = 2'd1,
    S_DONE = 2'd2
  } state_e;

  state_e             state_q, state_d;
  logic [3:0]         op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic               cin_q, cin_d;
  logic [CW-1:0]      cnt_q, cnt_d;
  logic [2*WIDTH-1:0] acc_q, acc_d;
  logic [2*WIDTH-1:0] res_q, res_d;
  logic               co_q, co_d;
  logic               dz_q, dz_d;
  logic               il_q, il_d;

  logic [2*WIDTH-1:0] alu_res;
  logic               alu_co;
  logic               alu_dz;
  logic               alu_il;
  logic [WIDTH:0]     add_s;
  logic [WIDTH:0]     sub_s;
  logic [WIDTH:0]     mul_s;
  logic [WIDTH:0]     div_r;
  logic [WIDTH:0]     div_n;
  logic               div_ge;
  logic [2*WIDTH-1:0] mul_acc;
  logic [2*WIDTH-1:0] div_acc;
  logic               multi;

  always_comb begin
    alu_res = '0;
    alu_co  = 1'b0;
    alu_dz  = 1'b0;
    alu_il  = 1'b0;
    add_s   = {1'b0, a_q} + {1'b0, b_q} + {{WIDTH{1'b0}}, cin_q};
    sub_s   = {1'b0, a_q} - {1'b0, b_q};
    unique case (op_q)
      OP_AND:  alu_res = {{WIDTH{1'b0}}, a_q & b_q};
      OP_NAND: alu_res = {{WIDTH{1'b0}}, ~(a_q & b_q)};
      OP_OR:   alu_res = {{WIDTH{1'b0}}, a_q | b_q};
      OP_NOR:  alu_res = {{WIDTH{1'b0}}, ~(a_q | b_q)};
      OP_XOR:  alu_res = {{WIDTH{1'b0}}, a_q ^ b_q};
      OP_XNOR: alu_res = {{WIDTH{1'b0}}, ~(a_q ^ b_q)};
      OP_NOT:  alu_res = {{WIDTH{1'b0}}, ~a_q};
      OP_ADD: begin
        alu_res = {{WIDTH{1'b0}}, add_s[WIDTH-1:0]};
        alu_co  = add_s[WIDTH];
      end
      OP_SUB: begin
        alu_res = {{WIDTH{1'b0}}, sub_s[WIDTH-1:0]};
        alu_co  = (a_q >= b_q);
      end
      OP_SHL: begin
        alu_res = {{WIDTH{1'b0}}, a_q[WIDTH-2:0], 1'b0};
        alu_co  = a_q[WIDTH-1];
      end
      OP_SHR: begin
        alu_res = {{WIDTH{1'b0}}, 1'b0, a_q[WIDTH-1:1]};
        alu_co  = a_q[0];
      end
      // Only reached on the single-cycle path, i.e. b == 0.
      OP_DIV: begin
        alu_res = {a_q, {WIDTH{1'b1}}};
        alu_dz  = 1'b1;
      end
      OP_MUL:  alu_res = '0;
      default: alu_il = 1'b1;
    endcase
  end

  // Product register {hi, lo}: lo starts as b and is consumed LSB first.
  always_comb begin
    mul_s   = {1'b0, acc_q[2*WIDTH-1:WIDTH]}
            + {1'b0, (acc_q[0] ? a_q : {WIDTH{1'b0}})};
    mul_acc = {mul_s, acc_q[WIDTH-1:1]};
  end

  // Division register {rem, quo}: quo starts as a, shifted out MSB first.
  always_comb begin
    div_r   = {acc_q[2*WIDTH-1:WIDTH], acc_q[WIDTH-1]};
    div_ge  = (div_r >= {1'b0, b_q});
    div_n   = div_ge ? (div_r - {1'b0, b_q}) : div_r;
    div_acc = {div_n[WIDTH-1:0], acc_q[WIDTH-2:0], div_ge};
  end

  assign multi = (op_q == OP_MUL) || ((op_q == OP_DIV) && (b_q != '0));

  always_comb begin
    state_d = state_q;
    op_d    = op_q;
    a_d     = a_q;
    b_d     = b_q;
    cin_d   = cin_q;
    cnt_d   = cnt_q;
    acc_d   = acc_q;
    res_d   = res_q;
    co_d    = co_q;
    dz_d    = dz_q;
    il_d    = il_q;
    unique case (state_q)
      S_IDLE: begin
        if (cmd_valid) begin
          op_d    = opcode;
          a_d     = a;
          b_d     = b;
          cin_d   = carry_in;
          cnt_d   = CW'(WIDTH - 1);
          acc_d   = {{WIDTH{1'b0}}, (opcode == OP_DIV) ? a : b};
          res_d   = '0;
          co_d    = 1'b0;
          dz_d    = 1'b0;
          il_d    = 1'b0;
          state_d = S_EXEC;
        end
      end
      S_EXEC: begin
        if (multi) begin
          acc_d = (op_q == OP_MUL) ? mul_acc : div_acc;
          if (cnt_q == '0) begin
            res_d   = acc_d;
            state_d = S_DONE;
          end else begin
            cnt_d = cnt_q - CW'(1);
          end
        end else begin
          res_d   = alu_res;
          co_d    = alu_co;
          dz_d    = alu_dz;
          il_d    = alu_il;
          state_d = S_DONE;
        end
      end
      S_DONE: begin
        if (res_ready) state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset) begin
      state_q <= S_IDLE;
      op_q    <= '0;
      a_q     <= '0;
      b_q     <= '0;
      cin_q   <= 1'b0;
      cnt_q   <= '0;
      acc_q   <= '0;
      res_q   <= '0;
      co_q    <= 1'b0;
      dz_q    <= 1'b0;
      il_q    <= 1'b0;
    end else begin
      state_q <= state_d;
      op_q    <= op_d;
      a_q     <= a_d;
      b_q     <= b_d;
      cin_q   <= cin_d;
      cnt_q   <= cnt_d;
      acc_q   <= acc_d;
      res_q   <= res_d;
      co_q    <= co_d;
      dz_q    <= dz_d;
      il_q    <= il_d;
    end
  end

  assign cmd_ready  = (state_q == S_IDLE);
  assign res_valid  = (state_q == S_DONE);
  assign busy       = (state_q != S_IDLE);
  assign result     = res_q;
  assign carry_out  = co_q;
  assign div_zero   = dz_q;
  assign illegal_op = il_q;

endmodule

// File: tb/tb_alu_sequencer.sv
// Scoreboard bench for alu_sequencer: driver pushes model results,
// a negedge monitor pops and compares values and latency.
module tb_alu_sequencer;

  logic       clock;
  logic       reset;
  logic       cmd_valid;
  logic       cmd_ready;
  logic [3:0] opcode;
  logic [3:0] a;
  logic [3:0] b;
  logic       carry_in;
  logic       res_valid;
  logic       res_ready;
  logic [7:0] result;
  logic       carry_out;
  logic       div_zero;
  logic       illegal_op;
  logic       busy;

  alu_sequencer #(.WIDTH(4)) dut (
    .clock      (clock),
    .reset      (reset),
    .cmd_valid  (cmd_valid),
    .cmd_ready  (cmd_ready),
    .opcode     (opcode),
    .a          (a),
    .b          (b),
    .carry_in   (carry_in),
    .res_valid  (res_valid),
    .res_ready  (res_ready),
    .result     (result),
    .carry_out  (carry_out),
    .div_zero   (div_zero),
    .illegal_op (illegal_op),
    .busy       (busy)
  );

  typedef struct {
    logic [7:0] res;
    logic       co;
    logic       dz;
    logic       il;
    int         lat;
    int         p;
  } exp_t;

  exp_t sb[$];
  int   n_cmp  = 0;
  int   n_fail = 0;
  int   cyc    = 0;
  int   bp_cnt = 0;
  bit   seen   = 0;

  initial clock = 1'b0;
  always #5 clock = ~clock;

  always @(posedge clock) cyc <= cyc + 1;

  task automatic check(input string nm, input logic [31:0] got,
                       input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", nm, got, want);
    end
  endtask

  function automatic exp_t model(input int op, input int x, input int y,
                                 input int c);
    exp_t e;
    int   s;
    e.res = 8'h00;
    e.co  = 1'b0;
    e.dz  = 1'b0;
    e.il  = 1'b0;
    e.lat = 2;
    e.p   = 0;
    s     = 0;
    case (op)
      0: e.res = 8'(x & y);
      1: e.res = 8'(~(x & y) & 15);
      2: e.res = 8'(x | y);
      3: e.res = 8'(~(x | y) & 15);
      4: e.res = 8'(x ^ y);
      5: e.res = 8'(~(x ^ y) & 15);
      6: e.res = 8'(~x & 15);
      7: begin
        s     = x + y + c;
        e.res = 8'(s % 16);
        e.co  = (s >= 16);
      end
      8: begin
        e.res = 8'((x - y + 16) % 16);
        e.co  = (x >= y);
      end
      9: begin
        e.res = 8'(x * y);
        e.lat = 5;
      end
      10: begin
        if (y == 0) begin
          e.res = 8'(x * 16 + 15);
          e.dz  = 1'b1;
        end else begin
          e.res = 8'((x % y) * 16 + x / y);
          e.lat = 5;
        end
      end
      11: begin
        e.res = 8'((x * 2) % 16);
        e.co  = (x >= 8);
      end
      12: begin
        e.res = 8'(x / 2);
        e.co  = (x % 2 == 1);
      end
      default: e.il = 1'b1;
    endcase
    return e;
  endfunction

  // Inputs change 1 time unit after each rising edge.
  task automatic step();
    @(posedge clock);
    #1;
    if (bp_cnt > 0) begin
      res_ready = 1'b0;
      bp_cnt--;
    end else begin
      res_ready = ($urandom_range(0, 3) != 0);
    end
  endtask

  task automatic idle_steps(input int n);
    cmd_valid = 1'b0;
    repeat (n) step();
  endtask

  task automatic issue(input int op, input int x, input int y, input int c);
    exp_t e;
    int   n;
    n = 0;
    step();
    cmd_valid = 1'b1;
    opcode    = 4'(op);
    a         = 4'(x);
    b         = 4'(y);
    carry_in  = 1'(c);
    while (!cmd_ready && n < 60) begin
      step();
      n++;
    end
    if (!cmd_ready) begin
      check("accept_timeout", 32'(cmd_ready), 32'd1);
      cmd_valid = 1'b0;
    end else begin
      check("no_overlap", 32'(sb.size()), 32'd0);
      e   = model(op, x, y, c);
      e.p = cyc;
      sb.push_back(e);
      step();
      // Operands scrambled right after the accept edge; must be ignored.
      cmd_valid = 1'b1;
      opcode    = 4'($urandom);
      a         = 4'($urandom);
      b         = 4'($urandom);
      carry_in  = 1'($urandom);
    end
  endtask

  always @(negedge clock) begin
    if (!reset) begin
      seen = 0;
    end else if (res_valid) begin
      if (sb.size() == 0) begin
        check("unexpected_valid", 32'(res_valid), 32'd0);
      end else begin
        if (!seen) begin
          seen = 1;
          check("latency", 32'(cyc - sb[0].p), 32'(sb[0].lat));
        end
        check("result", 32'({result, carry_out, div_zero, illegal_op}),
              32'({sb[0].res, sb[0].co, sb[0].dz, sb[0].il}));
        check("ready_in_done", 32'({cmd_ready, busy}), 32'b01);
        if (res_ready) begin
          void'(sb.pop_front());
          seen = 0;
        end
      end
    end
  end

  initial begin
    int n;
    reset     = 1'b0;
    cmd_valid = 1'b0;
    opcode    = 4'd0;
    a         = 4'd0;
    b         = 4'd0;
    carry_in  = 1'b0;
    res_ready = 1'b0;
    repeat (3) step();
    reset = 1'b1;
    check("rst_ctrl", 32'({cmd_ready, res_valid, busy}), 32'b100);
    check("rst_data", 32'({result, carry_out, div_zero, illegal_op}), 32'd0);

    issue(7, 15, 1, 1);
    issue(8, 3, 5, 1);
    issue(9, 15, 15, 0);
    issue(9, 0, 9, 0);
    issue(10, 13, 4, 0);
    issue(10, 7, 0, 0);
    issue(4, 12, 3, 0);
    bp_cnt = 6;
    issue(14, 5, 6, 1);
    issue(11, 9, 0, 0);
    issue(12, 9, 0, 0);
    issue(6, 10, 3, 0);
    issue(8, 9, 9, 0);
    issue(10, 15, 1, 0);

    // Reset in the middle of a multiply; the result must never appear.
    issue(9, 15, 15, 0);
    cmd_valid = 1'b0;
    step();
    reset = 1'b0;
    sb.delete();
    step();
    step();
    reset = 1'b1;
    check("midrst_ctrl", 32'({cmd_ready, res_valid, busy}), 32'b100);
    check("midrst_data", 32'({result, carry_out, div_zero, illegal_op}), 32'd0);
    idle_steps(10);
    check("midrst_quiet", 32'({res_valid, busy}), 32'b00);

    for (int i = 0; i < 150; i++) begin
      int y;
      y = ($urandom_range(0, 7) == 0) ? 0 : int'($urandom_range(0, 15));
      issue(int'($urandom_range(0, 15)), int'($urandom_range(0, 15)), y,
            int'($urandom_range(0, 1)));
    end

    cmd_valid = 1'b0;
    n = 0;
    while (sb.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check("drain", 32'(sb.size()), 32'd0);
    idle_steps(3);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
